// File: rtl/mux_pkg.sv
//==============================================================================
// Module      : mux_pkg
// Description : Shared constants and helpers for the mux_rr_n datapath mux.
// Revision    : 1.0  initial release
//==============================================================================
`default_nettype none

package mux_pkg;

  // Selection modes for the channel grant.
  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_RR     = 1'b1;

  // Ceiling log2, used to size channel-index fields.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mux_rr_n_rr_arbiter.sv
//==============================================================================
// Module      : rr_arbiter
// Description : Round-robin request arbiter. The search starts one past ptr and
//               wraps modulo NCH, so the last-served channel is checked last.
// Revision    : 1.0  initial release
//==============================================================================
`default_nettype none

module rr_arbiter #(
  parameter int NCH  = 4,
  parameter int SELW = 2
) (
  input  logic [NCH-1:0]  req,
  input  logic [SELW-1:0] ptr,
  input  logic            en,
  output logic [NCH-1:0]  gnt,
  output logic [SELW-1:0] gnt_idx
);

  // Pick the first requester after ptr in circular order; en=0 masks everything.
  always_comb begin : p_search
    logic w_found;
    gnt     = '0;
    gnt_idx = '0;
    w_found = 1'b0;
    if (en) begin
      for (int k = 1; k <= NCH; k++) begin
        for (int i = 0; i < NCH; i++) begin
          if (!w_found && req[i] && (i == ((int'(ptr) + k) % NCH))) begin
            w_found = 1'b1;
            gnt[i]  = 1'b1;
            gnt_idx = SELW'(i);
          end
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mux_rr_n.sv
//==============================================================================
// Module      : mux_rr_n
// Description : N-channel registered multiplexer with valid/ready handshakes,
//               direct-select and round-robin grant modes.
// Revision    : 1.0  initial release
//==============================================================================
`default_nettype none

module mux_rr_n
  import mux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NCH   = 4,
  parameter int SELW  = (clog2(NCH) < 1) ? 1 : clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic [NCH*WIDTH-1:0] din,
  input  logic [NCH-1:0]       din_valid,
  output logic [NCH-1:0]       din_ready,
  output logic [WIDTH-1:0]     dout,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic [SELW-1:0]      dout_ch
);

  logic [WIDTH-1:0] r_dout;
  logic             r_dout_valid;
  logic [SELW-1:0]  r_dout_ch;
  logic [SELW-1:0]  r_ptr;

  logic             w_load_en;
  logic [NCH-1:0]   w_dir_gnt;
  logic [NCH-1:0]   w_rr_gnt;
  logic [SELW-1:0]  w_rr_idx;
  logic [NCH-1:0]   w_gnt;
  logic [SELW-1:0]  w_gnt_idx;
  logic             w_xfer;
  logic [WIDTH-1:0] w_sel_data;

  // The output slot can take a new word when empty or being drained now.
  assign w_load_en = !r_dout_valid || dout_ready;

  // Direct grant: compare sel against every legal index so an out-of-range
  // sel simply matches nothing.
  always_comb begin
    w_dir_gnt = '0;
    for (int i = 0; i < NCH; i++) begin
      if (sel == SELW'(i)) begin
        w_dir_gnt[i] = din_valid[i];
      end
    end
  end

  rr_arbiter #(
    .NCH  (NCH),
    .SELW (SELW)
  ) u_rr_arbiter (
    .req     (din_valid),
    .ptr     (r_ptr),
    .en      (mode == MODE_RR),
    .gnt     (w_rr_gnt),
    .gnt_idx (w_rr_idx)
  );

  assign w_gnt     = (mode == MODE_RR) ? w_rr_gnt : w_dir_gnt;
  assign w_gnt_idx = (mode == MODE_RR) ? w_rr_idx : sel;

  // Reset gates ready so nothing is accepted during the reset cycle.
  assign din_ready = w_gnt & {NCH{w_load_en && !reset}};
  assign w_xfer    = |din_ready;

  // One-hot grant selects the winning channel's word.
  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < NCH; i++) begin
      if (w_gnt[i]) begin
        w_sel_data = w_sel_data | din[i*WIDTH +: WIDTH];
      end
    end
  end

  // Output register and round-robin pointer; ptr follows every transfer in
  // both modes so a later switch to round-robin stays fair.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_dout_ch    <= '0;
      r_ptr        <= SELW'(NCH - 1);
    end else if (w_xfer) begin
      r_dout       <= w_sel_data;
      r_dout_valid <= 1'b1;
      r_dout_ch    <= w_gnt_idx;
      r_ptr        <= w_gnt_idx;
    end else if (dout_ready) begin
      r_dout_valid <= 1'b0;
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign dout_ch    = r_dout_ch;

endmodule

`default_nettype wire

// File: tb/tb_mux_rr_n.sv
//==============================================================================
// Module      : tb_mux_rr_n
// Description : Scoreboard bench for mux_rr_n, a 4-channel and a 3-channel
//               instance driven side by side.
// Revision    : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_mux_rr_n;

  logic         clk;
  logic         reset;
  logic         mode   [2];
  logic [1:0]   sel    [2];
  logic [127:0] din    [2];
  logic [3:0]   valid  [2];
  logic         dready [2];

  logic [3:0]  rdy0;
  logic [2:0]  rdy1;
  logic [31:0] dout0, dout1;
  logic        dval0, dval1;
  logic [1:0]  dch0, dch1;

  logic [33:0] q0[$];
  logic [33:0] q1[$];
  int          mptr [2];
  logic        prev_rst;
  int          total;
  int          bad;

  mux_rr_n #(.WIDTH(32), .NCH(4)) dut4 (
    .clk(clk), .reset(reset), .mode(mode[0]), .sel(sel[0]),
    .din(din[0]), .din_valid(valid[0]), .din_ready(rdy0),
    .dout(dout0), .dout_valid(dval0), .dout_ready(dready[0]), .dout_ch(dch0)
  );

  mux_rr_n #(.WIDTH(32), .NCH(3)) dut3 (
    .clk(clk), .reset(reset), .mode(mode[1]), .sel(sel[1]),
    .din(din[1][95:0]), .din_valid(valid[1][2:0]), .din_ready(rdy1),
    .dout(dout1), .dout_valid(dval1), .dout_ready(dready[1]), .dout_ch(dch1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int d, input logic [63:0] act,
                     input logic [63:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s dut%0d t=%0t: got %h expected %h", name, d, $time, act, exp);
    end
  endtask

  // Monitor and reference model: the output slot is a queue holding at most
  // one word; grants follow the selection rules directly.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      int          nch;
      int          qs;
      int          g;
      int          c;
      logic [3:0]  a_rdy;
      logic [3:0]  e_rdy;
      logic [33:0] a_word;
      logic        a_val;
      logic [33:0] front;
      logic        load;
      nch    = (d == 0) ? 4 : 3;
      a_rdy  = (d == 0) ? rdy0 : {1'b0, rdy1};
      a_word = (d == 0) ? {dch0, dout0} : {dch1, dout1};
      a_val  = (d == 0) ? dval0 : dval1;
      qs     = (d == 0) ? q0.size() : q1.size();
      if (reset) begin
        chk("reset_ready", d, 64'(a_rdy), 64'd0);
        if (prev_rst) begin
          chk("reset_valid", d, 64'(a_val), 64'd0);
          chk("reset_word", d, 64'(a_word), 64'd0);
        end
        if (d == 0) q0.delete(); else q1.delete();
        mptr[d] = nch - 1;
      end else begin
        chk("dout_valid", d, 64'(a_val), 64'(qs != 0));
        if (qs != 0) begin
          front = (d == 0) ? q0[0] : q1[0];
          chk("dout_word", d, 64'(a_word), 64'(front));
          if (dready[d]) begin
            if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
          end
        end
        load = (qs == 0) || dready[d];
        g = -1;
        if (load) begin
          if (mode[d] == 1'b0) begin
            if (int'(sel[d]) < nch && valid[d][sel[d]]) g = int'(sel[d]);
          end else begin
            for (int k = 1; k <= nch; k++) begin
              c = (mptr[d] + k) % nch;
              if (g < 0 && valid[d][c]) g = c;
            end
          end
        end
        e_rdy = (g >= 0) ? (4'b0001 << g) : 4'b0000;
        chk("din_ready", d, 64'(a_rdy), 64'(e_rdy));
        if (g >= 0) begin
          front = {g[1:0], din[d][g*32 +: 32]};
          if (d == 0) q0.push_back(front); else q1.push_back(front);
          mptr[d] = g;
        end
      end
    end
    prev_rst = reset;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int d);
    valid[d]  = '0;
    dready[d] = 1'b1;
    mode[d]   = 1'b0;
    sel[d]    = '0;
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    prev_rst = 1'b0;
    mptr[0]  = 3;
    mptr[1]  = 2;
    reset    = 1'b1;
    for (int d = 0; d < 2; d++) begin
      mode[d]   = 1'b1;
      sel[d]    = '0;
      din[d]    = {32'h0C0C_0003, 32'h0B0B_0002, 32'h0A0A_0001, 32'h0909_0000};
      valid[d]  = 4'hF;
      dready[d] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Round-robin with every channel valid.
    repeat (9) tick();

    // Direct select stepping through channels with din_i = i.
    din[0]  = {32'd3, 32'd2, 32'd1, 32'd0};
    mode[0] = 1'b0;
    for (int s = 0; s < 4; s++) begin
      sel[0] = 2'(s);
      tick();
    end

    // Round-robin with only channels 1 and 3 requesting.
    mode[0]  = 1'b1;
    valid[0] = 4'b1010;
    repeat (6) tick();

    // Back-pressure: load A5A5_0002 from channel 2, then stall.
    mode[0]  = 1'b0;
    sel[0]   = 2'd2;
    valid[0] = 4'hF;
    din[0]   = {32'h1111_0003, 32'hA5A5_0002, 32'h1111_0001, 32'h1111_0000};
    tick();
    dready[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      valid[0] = 4'($urandom);
      mode[0]  = 1'($urandom);
      tick();
    end
    dready[0] = 1'b1;
    valid[0]  = 4'hF;
    mode[0]   = 1'b1;
    repeat (4) tick();

    // Three-channel instance: out-of-range select, then switch to RR.
    idle(0);
    mode[1]  = 1'b0;
    sel[1]   = 2'd3;
    valid[1] = 4'hF;
    repeat (3) tick();
    sel[1] = 2'd1;
    tick();
    mode[1] = 1'b1;
    repeat (4) tick();

    // Randomised traffic on both instances.
    for (int n = 0; n < 300; n++) begin
      for (int d = 0; d < 2; d++) begin
        mode[d]   = 1'($urandom);
        sel[d]    = 2'($urandom);
        valid[d]  = 4'($urandom);
        dready[d] = ($urandom_range(0, 3) != 0);
        din[d]    = {$urandom, $urandom, $urandom, $urandom};
      end
      tick();
    end

    // Reset while the output is held under back-pressure.
    for (int d = 0; d < 2; d++) begin
      mode[d]   = 1'b1;
      valid[d]  = 4'hF;
      dready[d] = 1'b0;
    end
    repeat (2) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int d = 0; d < 2; d++) dready[d] = 1'b1;
    repeat (5) tick();

    idle(0);
    idle(1);
    repeat (3) tick();
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mux_rr_n.md
# mux_rr_n

Parameterised N-channel, WIDTH-bit registered multiplexer with per-channel valid/ready handshake and two selection modes: direct select and round-robin arbitration. Next generation of the 4:1 32-bit combinational datapath mux. It sits where several producers share one consumer, such as writeback sources or memory request ports. It adds back-pressure, a registered output and fair arbitration.

## Interface
- `WIDTH`, 32, data width per channel
- `NCH`, 4, number of input channels (2..16, need not be a power of two)
- `SELW`, derived: max(1, clog2(NCH)), select/channel-index width

- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high reset
- `mode`  in  1  0 = MODE_DIRECT (use `sel`), 1 = MODE_RR (round-robin)
- `sel`  in  SELW  channel index used in MODE_DIRECT
- `din`  in  NCH*WIDTH  flattened inputs; channel i = din[i*WIDTH +: WIDTH]
- `din_valid`  in  NCH  per-channel data valid
- `din_ready`  out  NCH  per-channel accept; at most one bit high per cycle
- `dout`  out  WIDTH  registered output data
- `dout_valid`  out  1  output register holds data
- `dout_ready`  in  1  consumer accepts `dout` this cycle
- `dout_ch`  out  SELW  index of the channel that produced `dout`

## Operation
- `load_en` = !dout_valid | dout_ready. The output register may be refilled when it is empty or being drained in the same cycle.
- Grant in MODE_DIRECT: the channel is `sel` when `sel` < NCH and din_valid[sel]=1. Otherwise there is no grant. An out-of-range `sel` never grants and never raises X.
- Grant in MODE_RR: the first channel with din_valid=1, searching from ptr+1 upward and wrapping modulo NCH. ptr is included last.
- din_ready[i] = grant[i] & load_en. This is combinational from din_valid, sel, mode, ptr and dout_valid/dout_ready.
- Input transfer: din_valid[i] & din_ready[i]. On transfer:
  - dout <= din[i]
  - dout_ch <= i
  - dout_valid <= 1
  - ptr <= i, in both modes, so switching to RR continues fairly
- Output transfer with no input transfer (dout_valid & dout_ready, no grant): dout_valid <= 0. dout and dout_ch hold their values.
- Stall (dout_valid & !dout_ready): dout, dout_ch and dout_valid hold, and all din_ready=0.
- A `mode` or `sel` change takes effect on the next cycle's grant. Data already held in the output register is unaffected.

## Timing
- Reset values: dout=0, dout_valid=0, dout_ch=0, ptr=NCH-1, so channel 0 wins the first RR grant. All din_ready are 0 during the reset cycle.
- Latency: 1 cycle from input transfer to dout_valid/dout.
- Throughput: 1 word/cycle while dout_ready=1 and any eligible channel is valid.
- Reset mid-operation: held data is discarded and outputs take their reset values on the next edge. There is no partial transfer.
- Simultaneous drain and fill in one cycle: the new word replaces the old and dout_valid stays 1.
- RR wrap: with ptr=NCH-1, the search order is 0,1,…,NCH-1.
- Only ptr and the output register are stateful. There are no combinational paths from din to dout.

## Structure
- Shared package/header `mux_pkg`:
  - MODE_DIRECT=1'b0, MODE_RR=1'b1
  - a clog2 function for deriving SELW
- Sub-module `rr_arbiter` (NCH, SELW):
  - inputs: req[NCH], ptr, en
  - outputs: one-hot gnt[NCH] and gnt_idx[SELW]
  - en=0 forces gnt=0
- Top level: grant select between direct and RR, output register, ptr register.

## Test plan
- Reset: hold reset 2 cycles with all din_valid=1 → dout=0, dout_valid=0, dout_ch=0, din_ready=0. First RR grant after release goes to channel 0.
- Direct mode: NCH=4, din_i=i, all valid, dout_ready=1, sel stepping 0..3 each cycle → one cycle later dout=0,1,2,3 with dout_ch=sel. Only din_ready[sel] is high.
- Round-robin fairness: all 4 channels valid continuously, dout_ready=1 → dout_ch sequence 0,1,2,3,0,1,… with no gaps. With only channels 1 and 3 valid → 1,3,1,3.
- Back-pressure: fill with din_2=32'hA5A5_0002, then hold dout_ready=0 for 5 cycles while channels toggle → dout stays A5A5_0002, all din_ready=0. Release → next word arrives the same cycle as the drain, and dout_valid never drops.
- Boundary: NCH=3, sel=3 in MODE_DIRECT → no grant, dout_valid falls after drain, no X on outputs. Switch to MODE_RR after channel 1 transfer → next grant goes to channel 2.
- Reset mid-stream: assert reset while dout_valid=1 and dout_ready=0 → next edge gives dout_valid=0, ptr reset, and the first post-reset grant goes to channel 0.
